// File: rtl/fourbank_drain_reader_pkg.sv
// Shared constants and FSM encoding for the four-bank FIFO drain reader.
// Holds DATA_W, NBANK, the reader state type and a mask popcount helper.
package fourbank_drain_reader_pkg;

    localparam int DATA_W = 8;
    localparam int NBANK  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_REQ,
        S_RESP,
        S_BACKOFF
    } state_t;

    function automatic logic [2:0] popcount4(input logic [NBANK-1:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/fourbank_out_buf.sv
// First-word fall-through circular output buffer for the drain reader.
// Ports: clk/rst, push/push_data in, m_valid/m_data/m_ready stream, occ out.
module fourbank_out_buf
    import fourbank_drain_reader_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [CW-1:0]     occ
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pop;

    assign m_valid = (cnt_q != '0);
    assign m_data  = mem_q[rd_ptr_q];
    assign occ     = cnt_q;
    assign pop     = m_valid & m_ready;

    // Pointers are PW bits wide and DEPTH is a power of two, so they wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fourbank_drain_reader.sv
// Master-side read engine: round-robin scans four FIFO banks, issues one
// read at a time and streams hits out. Ports: clk/rst, enable, bank_mask,
// rd_en/rd_id request, fifo_data/fifo_valid response, m_* stream, busy,
// hit_count.
module fourbank_drain_reader
    import fourbank_drain_reader_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int BACKOFF   = 8,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NBANK-1:0]  bank_mask,
    output logic              rd_en,
    output logic [1:0]        rd_id,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic [15:0]       hit_count
);

    localparam int OW  = $clog2(OUT_DEPTH + 1);
    localparam int OW1 = OW + 1;
    localparam int BW  = $clog2(BURST_MAX + 1);
    localparam int KW  = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

    state_t        state_q, state_d;
    logic [1:0]    cur_bank_q, cur_bank_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [2:0]    miss_cnt_q, miss_cnt_d;
    logic [KW-1:0] backoff_cnt_q, backoff_cnt_d;
    logic [15:0]   hit_count_q, hit_count_d;
    logic          rd_en_q, rd_en_d;
    logic [1:0]    rd_id_q, rd_id_d;

    logic          push;
    logic [OW-1:0] occ;
    logic [OW:0]   occ_after;
    logic          space_now;
    logic          space_after;
    logic [2:0]    miss_next;

    assign rd_en     = rd_en_q;
    assign rd_id     = rd_id_q;
    assign busy      = (state_q != S_IDLE);
    assign hit_count = hit_count_q;

    // A slot must be free at issue so the registered response never drops.
    assign space_now = (occ < OW'(OUT_DEPTH));
    // Occupancy once this cycle's hit is pushed and any pop is taken.
    assign occ_after = OW1'(occ) + OW1'(1) - OW1'(m_valid & m_ready);
    assign space_after = (occ_after < OW1'(OUT_DEPTH));
    assign miss_next = miss_cnt_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        cur_bank_d    = cur_bank_q;
        burst_cnt_d   = burst_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        backoff_cnt_d = backoff_cnt_q;
        hit_count_d   = hit_count_q;
        rd_id_d       = rd_id_q;
        push          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable && bank_mask != '0) state_d = S_SEEK;
            end
            S_SEEK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (!bank_mask[cur_bank_q]) begin
                    cur_bank_d = cur_bank_q + 2'd1;
                end else if (space_now) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (fifo_valid) begin
                    push        = 1'b1;
                    hit_count_d = hit_count_q + 16'd1;
                    miss_cnt_d  = '0;
                    if (burst_cnt_q == BW'(BURST_MAX - 1)) begin
                        burst_cnt_d = '0;
                        cur_bank_d  = cur_bank_q + 2'd1;
                        state_d     = S_SEEK;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                        state_d     = space_after ? S_REQ : S_SEEK;
                    end
                end else begin
                    burst_cnt_d = '0;
                    cur_bank_d  = cur_bank_q + 2'd1;
                    // >= so a mask shrunk mid-sweep still ends the sweep.
                    if (miss_next >= popcount4(bank_mask)) begin
                        miss_cnt_d = '0;
                        state_d    = S_BACKOFF;
                    end else begin
                        miss_cnt_d = miss_next;
                        state_d    = S_SEEK;
                    end
                end
            end
            S_BACKOFF: begin
                if (backoff_cnt_q == KW'(BACKOFF - 1)) begin
                    backoff_cnt_d = '0;
                    state_d       = enable ? S_SEEK : S_IDLE;
                end else begin
                    backoff_cnt_d = backoff_cnt_q + KW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Request is registered: raised on entry to REQ for that one cycle.
        rd_en_d = (state_d == S_REQ);
        if (rd_en_d) rd_id_d = cur_bank_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cur_bank_q    <= '0;
            burst_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            backoff_cnt_q <= '0;
            hit_count_q   <= '0;
            rd_en_q       <= 1'b0;
            rd_id_q       <= '0;
        end else begin
            state_q       <= state_d;
            cur_bank_q    <= cur_bank_d;
            burst_cnt_q   <= burst_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            backoff_cnt_q <= backoff_cnt_d;
            hit_count_q   <= hit_count_d;
            rd_en_q       <= rd_en_d;
            rd_id_q       <= rd_id_d;
        end
    end

    fourbank_out_buf #(
        .DEPTH (OUT_DEPTH),
        .CW    (OW)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_data),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .occ       (occ)
    );

endmodule
